// File: rtl/alu_serial_pkg.sv
// Shared types and slice decode for the bit-serial ALU sequencer.
// Opcode, state and slice-control encodings live here.
package alu_serial_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_NOR = 3'b110,
    OP_RSV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLTFIX,
    S_DONE
  } state_t;

  localparam logic [2:0] SLICE_AND  = 3'b000;
  localparam logic [2:0] SLICE_OR   = 3'b010;
  localparam logic [2:0] SLICE_XOR  = 3'b011;
  localparam logic [2:0] SLICE_ADD  = 3'b100;
  localparam logic [2:0] SLICE_LESS = 3'b110;

  typedef struct packed {
    logic [2:0] op;
    logic       ainv;
    logic       binv;
  } slice_ctrl_t;

  function automatic slice_ctrl_t slice_decode(
    input alu_op_t op
  );
    slice_ctrl_t c;
    c.op   = SLICE_ADD;
    c.ainv = 1'b0;
    c.binv = 1'b0;
    unique case (1'b1)
      (op == OP_AND): c.op = SLICE_AND;
      (op == OP_OR):  c.op = SLICE_OR;
      (op == OP_XOR): c.op = SLICE_XOR;
      (op == OP_SUB),
      (op == OP_SLT): c.binv = 1'b1;
      (op == OP_NOR): begin
        c.op   = SLICE_AND;
        c.ainv = 1'b1;
        c.binv = 1'b1;
      end
      default: c.op = SLICE_ADD;
    endcase
    return c;
  endfunction

  function automatic logic carry_init(
    input alu_op_t op
  );
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Reserved opcode runs as ADD, so it reports ADD status too.
  function automatic logic is_addsub(
    input alu_op_t op
  );
    return (op == OP_ADD) || (op == OP_SUB)
        || (op == OP_RSV);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_alu1.sv
// One-bit ALU slice: optional operand inversion, full adder,
// and a small result mux selected by the slice opcode.
module alu_serial_ctrl_alu1
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       sum
);

  logic aa;
  logic bb;

  assign aa   = a ^ ainvert;
  assign bb   = b ^ binvert;
  assign sum  = aa ^ bb ^ cin;
  assign cout = (aa & bb) | (cin & (aa ^ bb));

  always_comb begin
    result = 1'b0;
    unique case (1'b1)
      (op == SLICE_AND):  result = aa & bb;
      (op == SLICE_OR):   result = aa | bb;
      (op == SLICE_XOR):  result = aa ^ bb;
      (op == SLICE_ADD):  result = sum;
      (op == SLICE_LESS): result = less;
      default:            result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one slice stepped LSB-first over WIDTH cycles.
// Define ALU_SERIAL_STATUS_EN for overflow/zero and overflow-corrected SLT.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum_msb;
  logic             last;
  logic             set;
  logic             ovf_run;
  logic             zero_run;
  logic             zero_fix;
  logic [WIDTH-1:0] run_res;

  slice_ctrl_t ctl;
  logic [2:0]  s_op;
  logic        s_ainv;
  logic        s_binv;
  logic        s_less;
  logic        s_res;
  logic        s_cout;
  logic        s_sum;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign run_res = {s_res, result[WIDTH-1:1]};

  always_comb begin
    ctl    = slice_decode(op_q);
    s_op   = ctl.op;
    s_ainv = ctl.ainv;
    s_binv = ctl.binv;
    s_less = 1'b0;
    if (state == S_SLTFIX) begin
      s_op   = SLICE_LESS;
      s_ainv = 1'b0;
      s_binv = 1'b0;
      s_less = set;
    end
  end

  alu_serial_ctrl_alu1 u_alu1 (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .ainvert (s_ainv),
    .binvert (s_binv),
    .cin     (carry),
    .less    (s_less),
    .op      (s_op),
    .result  (s_res),
    .cout    (s_cout),
    .sum     (s_sum)
  );

`ifdef ALU_SERIAL_STATUS_EN
  logic cin_msb;

  always_ff @(posedge clk) begin
    if (reset)
      cin_msb <= 1'b0;
    else if (state == S_RUN && last)
      cin_msb <= carry;
  end

  // In SLTFIX the carry register already holds the MSB carry-out.
  assign set      = sum_msb ^ (cin_msb ^ carry);
  assign ovf_run  = is_addsub(op_q) & (carry ^ s_cout);
  assign zero_run = ~|run_res;
  assign zero_fix = ~s_res;
`else
  assign set      = sum_msb;
  assign ovf_run  = 1'b0;
  assign zero_run = 1'b0;
  assign zero_fix = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_AND;
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum_msb  <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= alu_op_t'(op);
            cnt   <= '0;
            carry <= carry_init(alu_op_t'(op));
            ready <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          result <= run_res;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= s_cout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum_msb <= s_sum;
            if (op_q == OP_SLT) begin
              state <= S_SLTFIX;
            end else begin
              cout     <= is_addsub(op_q) & s_cout;
              overflow <= ovf_run;
              zero     <= zero_run;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_SLTFIX: begin
          result   <= {{(WIDTH-1){1'b0}}, s_res};
          cout     <= carry;
          overflow <= 1'b0;
          zero     <= zero_fix;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl at WIDTH=8.
// Expected flags follow the ALU_SERIAL_STATUS_EN build setting.
module tb_alu_serial_ctrl;

  localparam int W = 8;

`ifdef ALU_SERIAL_STATUS_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct {
    int         id;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    int         lat;
    int         t0;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
    int         lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s op#%0d: got %0h expected %0h",
               nm, id, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", e.id, 32'(result), 32'(e.res));
        chk("cout", e.id, 32'(cout), 32'(e.c));
        chk("overflow", e.id, 32'(overflow), 32'(e.v));
        chk("zero", e.id, 32'(zero), 32'(e.z));
        chk("latency", e.id, 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", id, 32'(ready), 32'd1);
  endtask

  task automatic issue(input int id, input vec_t v,
                       input int hold);
    exp_t e;
    wait_ready(id);
    op    = v.op;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    e.id  = id;
    e.res = v.res;
    e.c   = v.c;
    e.v   = EN & v.v;
    e.z   = EN & (v.res == 8'h00);
    e.lat = v.lat;
    e.t0  = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (hold == 0) start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      a = 8'hFF - 8'(i);
      b = 8'h5A + 8'(i);
      op = 3'b001;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(negedge clk);
    chk("busy_ready", id, 32'(ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", -1, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready"}, -1, 32'(ready), 32'd1);
    chk({nm, "_done"}, -1, 32'(done), 32'd0);
    chk({nm, "_result"}, -1, 32'(result), 32'd0);
    chk({nm, "_cout"}, -1, 32'(cout), 32'd0);
    chk({nm, "_ovf"}, -1, 32'(overflow), 32'd0);
    chk({nm, "_zero"}, -1, 32'(zero), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t hv;

  initial begin
    vecs[0]  = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 9};
    vecs[1]  = '{3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 9};
    vecs[2]  = '{3'b011, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 9};
    vecs[3]  = '{3'b101, 8'h80, 8'h01,
                 EN ? 8'h01 : 8'h00, 1'b1, 1'b0, 10};
    vecs[4]  = '{3'b101, 8'h01, 8'h80,
                 EN ? 8'h00 : 8'h01, 1'b0, 1'b0, 10};
    vecs[5]  = '{3'b100, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 9};
    vecs[6]  = '{3'b110, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 9};
    vecs[7]  = '{3'b000, 8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, 9};
    vecs[8]  = '{3'b001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 9};
    vecs[9]  = '{3'b111, 8'hC8, 8'h40, 8'h08, 1'b1, 1'b0, 9};
    vecs[10] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 9};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    for (int i = 0; i < 11; i++) issue(i, vecs[i], 0);
    drain();

    // start held through RUN with changing operands
    hv = '{3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 9};
    issue(20, hv, 5);
    drain();

    // abort in the 4th RUN cycle
    wait_ready(30);
    op    = 3'b010;
    a     = 8'h11;
    b     = 8'h22;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    repeat (15) @(negedge clk);
    chk("abort_quiet", 30, 32'(exp_q.size()), 32'd0);

    // operation after abort still works
    issue(31, vecs[8], 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial ALU sequencer that drives one instance of the 1-bit ALU slice (ALU1) across WIDTH cycles to execute a full-width operation. It latches two operands and an opcode on a start handshake, steps the slice LSB-first while holding the carry in a register, resolves set-on-less-than in a final pass, and reports result and status with a one-cycle done pulse. It sits between instruction decode and the register-file writeback as the area-minimal ALU option.

## Interface

- WIDTH, 32, operand/result width in bits (>= 2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT, 110 NOR, 111 reserved (executes as ADD)
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse, result/flags valid
- result  out  WIDTH  held from done until next accepted start
- cout  out  1  carry out of MSB (ADD/SUB/SLT), else 0
- overflow  out  1  signed overflow (ADD/SUB), else 0
- zero  out  1  result == 0

## Operation

- States: IDLE, RUN, SLTFIX, DONE.
- IDLE: ready=1. start=1 latches a, b, op into shift registers; bit counter := 0; carry reg := 1 for SUB/SLT, else 0 -> RUN.
- RUN: slice driven with A=a_sh[0], B=b_sh[0], cin=carry, less=0. Slice controls per op: AND op=000; OR 010; ADD/reserved 100; SUB/SLT 100 with BInvert=1; XOR 011; NOR 000 with AInvert=1, BInvert=1. Slice result shifted into result reg at MSB, operands shifted right, carry := slice cout. At counter=WIDTH-1 capture cin_msb (carry into MSB) and sum_msb, then -> SLTFIX if SLT, else DONE.
- SLTFIX: set = sum_msb XOR (cin_msb XOR cout_msb). Slice driven with op=110, less=set; result := {WIDTH-1 zeros, slice result} -> DONE.
- DONE: done=1 one cycle; flags registered -> IDLE.
- overflow = cin_msb XOR cout_msb for ADD/SUB; 0 for SLT and logic ops. cout = final carry for ADD/SUB/SLT.
- start outside IDLE ignored (no queuing); operand changes after acceptance have no effect.
- Reset (any state, including mid-RUN): state IDLE, result=0, cout=0, overflow=0, zero=0, done=0, ready=1 next cycle; aborted op never produces done.

## Timing

- Cycle 0: start sampled in IDLE. Cycles 1..WIDTH: RUN, bit i processed in cycle i+1.
- Non-SLT: done high in cycle WIDTH+1. SLT: done in cycle WIDTH+2.
- ready returns high the cycle after done; back-to-back start accepted then.
- Throughput: one op per WIDTH+2 cycles (WIDTH+3 for SLT).
- All outputs registered; no combinational path from inputs to outputs except none (ready decoded from state register).

## Configuration

- ALU_SERIAL_STATUS_EN defined: overflow and zero computed as above.
- Undefined: overflow and zero tied to 0, cin_msb capture logic removed; SLT set then equals sum_msb (no overflow correction) -- documented limitation.

## Structure

- Package alu_serial_pkg: alu_op_t enum (op encodings above), state_t enum, slice operation constants (SLICE_AND=000, SLICE_OR=010, SLICE_XOR=011, SLICE_ADD=100, SLICE_LESS=110).
- One sub-module: ALU1 slice, instantiated once; opcode-to-slice-control decode kept as a function in the package.

## Test plan

- WIDTH=8, ADD a=0x7F b=0x01 -> result 0x80, cout 0, overflow 1, done exactly 9 cycles after start.
- SUB a=0x05 b=0x07 -> result 0xFE, cout 0, overflow 0, zero 0; SUB 0x33-0x33 -> 0x00, cout 1, zero 1.
- SLT a=0x80 b=0x01 -> result 0x01, done 10 cycles after start; SLT a=0x01 b=0x80 -> 0x00.
- XOR 0xF0,0xFF -> 0x0F; NOR 0x0F,0xF0 -> 0x00, zero 1; AND 0xAA,0x0F -> 0x0A; OR 0xA0,0x05 -> 0xA5.
- start held high through RUN with new a/b -> ignored, original result returned; reset asserted in 4th RUN cycle -> ready 1 next cycle, no done, all outputs 0.
- Build without ALU_SERIAL_STATUS_EN: ADD 0x7F+0x01 -> result 0x80, overflow 0, zero 0.
